// File: rtl/vga_timing_core.sv
// ---------------------------------------------------------------------------
// vga_timing_core
//
// Parametrised VGA timing generator with frame-synchronous object buffering.
// Produces pixel/line counters, delayed sync/de for renderer alignment, and
// line/frame pulses. Object coordinates from the game logic are staged and
// committed only at the start of vertical blanking, so the renderer never
// sees a position change mid-frame.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   vga_clk              pixel enable (one clk wide); all timing advances on it
//   obj_load             capture obj_x_in/obj_y_in into the staging buffer
//   obj_x_in, obj_y_in   packed coordinates, object 0 in the LSBs
//   obj_x, obj_y         committed coordinates for the renderer
//   obj_pending          staging holds data not yet committed
//   h_cnt, v_cnt         current column / line (undelayed)
//   de, hor_sync,        active video and syncs, delayed PIPE_DEPTH enables
//   ver_sync
//   line_start,          one-clk pulses after the edge where h_cnt (and v_cnt)
//   frame_start          became 0
//   vblank               level, v_cnt >= V_ACTIVE
// ---------------------------------------------------------------------------
module vga_timing_core #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DEPTH = 2,
    parameter int NUM_OBJ    = 4,
    parameter int COORD_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vga_clk,
    input  logic                       obj_load,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x_in,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y_in,
    output logic [NUM_OBJ*COORD_W-1:0] obj_x,
    output logic [NUM_OBJ*COORD_W-1:0] obj_y,
    output logic                       obj_pending,
    output logic [COORD_W-1:0]         h_cnt,
    output logic [COORD_W-1:0]         v_cnt,
    output logic                       de,
    output logic                       hor_sync,
    output logic                       ver_sync,
    output logic                       line_start,
    output logic                       frame_start,
    output logic                       vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Refuse to elaborate if the counters cannot hold a full line/frame.
    if (((H_TOTAL - 1) >> COORD_W) != 0 || ((V_TOTAL - 1) >> COORD_W) != 0) begin : g_width_check
        $fatal(1, "COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (PIPE_DEPTH < 0 || PIPE_DEPTH > 8) begin : g_depth_check
        $fatal(1, "PIPE_DEPTH must be in 0..8");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic               de_raw, hs_raw, vs_raw;
    logic               commit;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vga_clk) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Raw timing is decoded from the next counter values so that the first
    // pipeline stage lines up with h_cnt/v_cnt; PIPE_DEPTH adds stages after it.
    assign de_raw = (h_d < H_ACT) && (v_d < V_ACT);
    assign hs_raw = (h_d >= HS_START) && (h_d < HS_END);
    assign vs_raw = (v_d >= VS_START) && (v_d < VS_END);

    // Start of vertical blanking: the enable edge entering line V_ACTIVE.
    assign commit = vga_clk && (h_d == '0) && (v_d == V_ACT);

    logic [PIPE_DEPTH:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
    logic                line_q, frame_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the block samples the pre-edge value of its sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            de_pipe_q <= '0;
            hs_pipe_q <= {(PIPE_DEPTH + 1){~HS_POL}};
            vs_pipe_q <= {(PIPE_DEPTH + 1){~VS_POL}};
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            line_q  <= vga_clk && (h_d == '0);
            frame_q <= vga_clk && (h_d == '0) && (v_d == '0);
            if (vga_clk) begin
                de_pipe_q[0] <= de_raw;
                hs_pipe_q[0] <= hs_raw ? HS_POL : ~HS_POL;
                vs_pipe_q[0] <= vs_raw ? VS_POL : ~VS_POL;
                for (int i = 1; i <= PIPE_DEPTH; i++) begin
                    de_pipe_q[i] <= de_pipe_q[i-1];
                    hs_pipe_q[i] <= hs_pipe_q[i-1];
                    vs_pipe_q[i] <= vs_pipe_q[i-1];
                end
            end
        end
    end

    logic [NUM_OBJ*COORD_W-1:0] stage_x_q, stage_y_q, obj_x_q, obj_y_q;
    logic                       pend_q;

    // A load on the commit edge publishes the old staging contents (read
    // before this edge) while capturing the new inputs, so pending stays set.
    // NOTE: the staging buffer is a register bank rather than a RAM and is
    // cleared on reset, so stale coordinates can never be committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_x_q <= '0;
            stage_y_q <= '0;
            obj_x_q   <= '0;
            obj_y_q   <= '0;
            pend_q    <= 1'b0;
        end else begin
            if (commit && pend_q) begin
                obj_x_q <= stage_x_q;
                obj_y_q <= stage_y_q;
            end
            if (obj_load) begin
                stage_x_q <= obj_x_in;
                stage_y_q <= obj_y_in;
                pend_q    <= 1'b1;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign de          = de_pipe_q[PIPE_DEPTH];
    assign hor_sync    = hs_pipe_q[PIPE_DEPTH];
    assign ver_sync    = vs_pipe_q[PIPE_DEPTH];
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign vblank      = (v_q >= V_ACT);
    assign obj_x       = obj_x_q;
    assign obj_y       = obj_y_q;
    assign obj_pending = pend_q;

endmodule
